// File: rtl/timer_bus_arbiter_if.sv
// Signal bundle between the bus masters, the timer arbiter and the timer slave register port.
interface timer_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
);
    logic [NUM_MASTERS-1:0]    m_req_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*AW-1:0] m_addr_i;
    logic [NUM_MASTERS*DW-1:0] m_data_i;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [DW-1:0]             m_data_o;
    logic [NUM_MASTERS-1:0]    grant_o;
    logic                      s_we_o;
    logic [AW-1:0]             s_addr_o;
    logic [DW-1:0]             s_data_o;
    logic [DW-1:0]             s_data_i;

    // Arbiter side: takes master requests and slave read data, drives everything else.
    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
        output m_ack_o, m_data_o, grant_o, s_we_o, s_addr_o, s_data_o
    );

    // Requester/slave-model side, the mirror of the arbiter view.
    modport master (
        output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
        input  m_ack_o, m_data_o, grant_o, s_we_o, s_addr_o, s_data_o
    );
endinterface

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter serialising master accesses to the timer register port as
// fixed IDLE -> ACCESS -> RESP transactions with a one-cycle ack pulse.
module timer_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned IW          = 2
) (
    input  logic               clk,
    input  logic               rstn,
    timer_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          last_ptr_q, last_ptr_d;
    logic                   we_q, we_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   s_we_q, s_we_d;
    logic [AW-1:0]          s_addr_q, s_addr_d;
    logic [DW-1:0]          s_data_q, s_data_d;

    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          cand;

    // Scan from the highest offset down so the nearest requester after last_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = int'(NUM_MASTERS); off >= 1; off--) begin
            cand = IW'((int'(last_ptr_q) + off) % int'(NUM_MASTERS));
            if (bus.m_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_ptr_d = last_ptr_q;
        we_d       = we_q;
        grant_d    = grant_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        s_we_d     = 1'b0;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = ACCESS;
                    idx_d            = win_idx;
                    we_d             = bus.m_we_i[win_idx];
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    s_we_d           = bus.m_we_i[win_idx];
                    s_addr_d         = bus.m_addr_i[AW * 32'(win_idx) +: AW];
                    s_data_d         = bus.m_data_i[DW * 32'(win_idx) +: DW];
                end
            end
            ACCESS: begin
                // Read data is captured here and presented with the ack in RESP.
                state_d      = RESP;
                rdata_d      = we_q ? '0 : bus.s_data_i;
                ack_d[idx_q] = 1'b1;
            end
            RESP: begin
                state_d    = IDLE;
                last_ptr_d = idx_q;
                grant_d    = '0;
                rdata_d    = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_ptr_q <= LAST_RST;
            we_q       <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_ptr_q <= last_ptr_d;
            we_q       <= we_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
        end
    end

    assign bus.m_ack_o  = ack_q;
    assign bus.m_data_o = rdata_q;
    assign bus.grant_o  = grant_q;
    assign bus.s_we_o   = s_we_q;
    assign bus.s_addr_o = s_addr_q;
    assign bus.s_data_o = s_data_q;
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: transaction-level round-robin model schedules expected
// per-cycle outputs; scenario tasks drive masters and compare every cycle.
module tb_timer_bus_arbiter;
    localparam int unsigned NM    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned VW    = 2 * NM + 1 + AW + 2 * DW;

    logic clk = 1'b0;
    logic rstn;

    timer_bus_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    timer_bus_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .IW(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    assign bus.s_data_i = mem[bus.s_addr_o[5:2]];

    int checks = 0;
    int errors = 0;
    int e = 0;
    int free_edge = 0;
    int last = NM - 1;

    logic [NM-1:0] exp_grant [DEPTH];
    logic [NM-1:0] exp_ack   [DEPTH];
    logic          exp_swe   [DEPTH];
    logic [DW-1:0] exp_mdata [DEPTH];
    logic [AW-1:0] cur_saddr;
    logic [DW-1:0] cur_sdata;
    logic [NM-1:0] hold_mask;

    function automatic logic [NM-1:0] onehot(input int i);
        return NM'(1) << i;
    endfunction

    function automatic logic bit_of(input logic [NM-1:0] v, input int i);
        logic [NM-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // First requester after 'from' in cyclic order, -1 when nobody asks.
    function automatic int pick(input logic [NM-1:0] req, input int from);
        for (int off = 1; off <= int'(NM); off++) begin
            if (bit_of(req, (from + off) % int'(NM))) return (from + off) % int'(NM);
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.grant_o, bus.m_ack_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o, bus.m_data_o};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_grant[e], exp_ack[e], exp_swe[e], cur_saddr, cur_sdata, exp_mdata[e]};
    endfunction

    // Model step at a rising edge; index e names the cycle that follows that edge.
    task automatic model_edge();
        int w;
        logic [AW-1:0] a;
        logic wr;
        e++;
        if (!rstn) begin
            for (int k = e; k < e + 4; k++) begin
                exp_grant[k] = '0;
                exp_ack[k]   = '0;
                exp_swe[k]   = 1'b0;
                exp_mdata[k] = '0;
            end
            free_edge = e + 1;
            last      = NM - 1;
            cur_saddr = '0;
            cur_sdata = '0;
        end else if (e >= free_edge && bus.m_req_i != '0) begin
            w  = pick(bus.m_req_i, last);
            a  = bus.m_addr_i[w*AW +: AW];
            wr = bit_of(bus.m_we_i, w);
            exp_grant[e]     = onehot(w);
            exp_swe[e]       = wr;
            exp_grant[e + 1] = onehot(w);
            exp_ack[e + 1]   = onehot(w);
            exp_mdata[e + 1] = wr ? '0 : mem[a[5:2]];
            cur_saddr        = a;
            cur_sdata        = bus.m_data_i[w*DW +: DW];
            last             = w;
            free_edge        = e + 3;
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        bus.m_req_i = bus.m_req_i | onehot(i);
        bus.m_we_i  = we ? (bus.m_we_i | onehot(i)) : (bus.m_we_i & ~onehot(i));
        bus.m_addr_i[i*AW +: AW] = addr;
        bus.m_data_i[i*DW +: DW] = data;
    endtask

    // Advance one cycle; acked masters drop req or, if held, issue a fresh request.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < int'(NM); i++) begin
            if (bit_of(exp_ack[e], i)) begin
                if (bit_of(hold_mask, i)) set_req(i, 1'($urandom), $urandom, $urandom);
                else bus.m_req_i = bus.m_req_i & ~onehot(i);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.m_req_i = 3'b111;
        repeat (3) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.grant_o !== 3'b000 || bus.s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant got %b/%b want 000/0", bus.grant_o, bus.s_we_o);
        end
        bus.m_req_i = '0;
        rstn = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_all_hold();
        int n = 0;
        hold_mask = 3'b111;
        for (int i = 0; i < int'(NM); i++) set_req(i, 1'($urandom), $urandom, $urandom);
        repeat (12) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_hold cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
            if (bus.m_ack_o != '0) begin
                checks++;
                if (bus.m_ack_o !== onehot(n % int'(NM))) begin
                    errors++;
                    $display("FAIL all_hold_order got %b want %b", bus.m_ack_o, onehot(n % int'(NM)));
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL all_hold_count got %0d want 4", n);
        end
        hold_mask = '0;
        repeat (12) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_drain cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_write();
        set_req(0, 1'b1, 32'h8, 32'hC8);
        tick();
        checks++;
        if ({bus.s_we_o, bus.s_addr_o, bus.s_data_o} !== {1'b1, 32'h8, 32'hC8}) begin
            errors++;
            $display("FAIL write_strobe got %b %h %h want 1 8 c8", bus.s_we_o, bus.s_addr_o, bus.s_data_o);
        end
        tick();
        checks++;
        if (bus.m_ack_o !== 3'b001 || bus.s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL write_ack got %b/%b want 001/0", bus.m_ack_o, bus.s_we_o);
        end
        repeat (3) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL write cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_read();
        set_req(1, 1'b0, 32'h4, 32'hDEAD);
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || bus.s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL read_access cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
        end
        tick();
        checks++;
        if (bus.m_ack_o !== 3'b010 || bus.m_data_o !== 32'h1234) begin
            errors++;
            $display("FAIL read_ack got %b %h want 010 1234", bus.m_ack_o, bus.m_data_o);
        end
        repeat (3) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL read cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        set_req(2, 1'b1, $urandom, $urandom);
        repeat (4) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL prio_m2 cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
        set_req(0, 1'b0, $urandom, $urandom);
        set_req(2, 1'b1, $urandom, $urandom);
        tick();
        checks++;
        if (bus.grant_o !== 3'b001) begin
            errors++;
            $display("FAIL prio_first got %b want 001", bus.grant_o);
        end
        repeat (8) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL prio cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, $urandom, $urandom);
        tick();
        checks++;
        if (bus.s_we_o !== 1'b1 || bus.grant_o !== 3'b010) begin
            errors++;
            $display("FAIL rmid_access got %b/%b want 1/010", bus.s_we_o, bus.grant_o);
        end
        rstn = 1'b0;
        tick();
        checks++;
        if (bus.s_we_o !== 1'b0 || bus.m_ack_o !== 3'b000 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rmid_cancel got %h want %h", obs_vec(), exp_vec());
        end
        rstn = 1'b1;
        set_req(0, 1'b1, $urandom, $urandom);
        tick();
        checks++;
        if (bus.grant_o !== 3'b001) begin
            errors++;
            $display("FAIL rmid_winner got %b want 001", bus.grant_o);
        end
        repeat (8) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rmid cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_drop();
        int acks = 0;
        set_req(0, 1'b0, $urandom, $urandom);
        tick();
        bus.m_req_i = '0;
        repeat (6) begin
            tick();
            if (bus.m_ack_o != '0) acks++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL drop_acks got %0d want 1", acks);
        end
    endtask

    task automatic test_random();
        repeat (300) begin
            rstn = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < int'(NM); i++)
                if (!bit_of(bus.m_req_i, i) && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom), $urandom, $urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
        rstn = 1'b1;
        repeat (12) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got %h want %h", e, obs_vec(), exp_vec());
            end
        end
        bus.m_req_i = '0;
        repeat (4) tick();
    endtask

    initial begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            exp_grant[k] = '0;
            exp_ack[k]   = '0;
            exp_swe[k]   = 1'b0;
            exp_mdata[k] = '0;
        end
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        mem[1]       = 32'h1234;
        cur_saddr    = '0;
        cur_sdata    = '0;
        hold_mask    = '0;
        rstn         = 1'b0;
        bus.m_req_i  = '0;
        bus.m_we_i   = '0;
        bus.m_addr_i = '0;
        bus.m_data_i = '0;

        test_reset();
        test_all_hold();
        test_write();
        test_read();
        test_priority();
        test_reset_mid();
        test_drop();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
